// File: rtl/alu_pipe_if.sv
`default_nettype none
// =============================================================================
// alu_pipe_if : operation/result handshake bundle for alu_pipe_unit
// Rev 1.0
// =============================================================================
interface alu_pipe_if #(
    parameter int REG_SIZE = 32,
    parameter int SHAMT_W  = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          opcode;
    logic                s_bit;
    logic                b_imm;
    logic [REG_SIZE-1:0] d0;
    logic [REG_SIZE-1:0] d1;
    logic [7:0]          imm;
    logic [3:0]          rot;
    logic [7:0]          shift;
    logic [SHAMT_W-1:0]  shift_amt;
    logic                mul;
    logic                out_valid;
    logic                out_ready;
    logic [REG_SIZE-1:0] data_out;
    logic                we;
    logic [3:0]          flags;

    modport master (
        output in_valid, opcode, s_bit, b_imm, d0, d1, imm, rot, shift, shift_amt, mul,
        output out_ready,
        input  in_ready, out_valid, data_out, we, flags
    );

    modport slave (
        input  in_valid, opcode, s_bit, b_imm, d0, d1, imm, rot, shift, shift_amt, mul,
        input  out_ready,
        output in_ready, out_valid, data_out, we, flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe_unit.sv
`default_nettype none
// =============================================================================
// alu_pipe_unit : registered ARM-style DP ALU with barrel shifter and NZCV flags;
//                 define ALU_MUL_EN for the iterative shift-add multiplier.
// Rev 1.0
// =============================================================================
module alu_pipe_unit #(
    parameter int REG_SIZE = 32,
    parameter int SHAMT_W  = 8
) (
    input  wire       clk,
    input  wire       reset,
    alu_pipe_if.slave bus
);
    localparam int C_LW    = $clog2(REG_SIZE);
    localparam int C_AMT_W = (SHAMT_W > 5) ? SHAMT_W : 5;

    localparam logic [3:0] C_OP_AND = 4'h0, C_OP_EOR = 4'h1, C_OP_SUB = 4'h2, C_OP_RSB = 4'h3;
    localparam logic [3:0] C_OP_ADD = 4'h4, C_OP_ADC = 4'h5, C_OP_SBC = 4'h6, C_OP_RSC = 4'h7;
    localparam logic [3:0] C_OP_TST = 4'h8, C_OP_TEQ = 4'h9, C_OP_CMP = 4'hA, C_OP_CMN = 4'hB;
    localparam logic [3:0] C_OP_ORR = 4'hC, C_OP_MOV = 4'hD, C_OP_BIC = 4'hE;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0
`ifdef ALU_MUL_EN
        , S_MUL = 1'b1
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [REG_SIZE-1:0] data_out_q, data_out_d;
    logic                we_q, we_d;
    logic [3:0]          flags_q, flags_d;

    function automatic logic [REG_SIZE-1:0] rotr(input logic [REG_SIZE-1:0] v, input int r);
        return (v >> r) | (v << (REG_SIZE - r));
    endfunction

    // ---------------- operand 2 / shifter ----------------
    logic [C_AMT_W-1:0]         w_amt;
    logic [REG_SIZE-1:0]        w_op2;
    logic                       w_sh_c;
    logic                       w_c_in;
    logic [REG_SIZE:0]          w_wide;
    logic signed [REG_SIZE:0]   w_wide_a;
    int                         w_rot_n;

    assign w_c_in = flags_q[1];

    always_comb begin
        w_amt    = bus.shift[0] ? C_AMT_W'(bus.shift_amt) : C_AMT_W'(bus.shift[7:3]);
        w_op2    = bus.d1;
        w_sh_c   = w_c_in;
        w_wide   = '0;
        w_wide_a = '0;
        w_rot_n  = 0;
        if (bus.b_imm) begin
            w_rot_n = (int'(bus.rot) * 2) % REG_SIZE;
            w_op2   = rotr(REG_SIZE'(bus.imm), w_rot_n);
            w_sh_c  = (bus.rot != 4'd0) ? w_op2[REG_SIZE-1] : w_c_in;
        end else if (w_amt != '0) begin
            // The extra bit on the wide vectors catches the last bit shifted out;
            // shifts past the width naturally give zero data and zero carry.
            unique case (bus.shift[2:1])
                2'd0: begin
                    w_wide = {1'b0, bus.d1} << w_amt;
                    w_op2  = w_wide[REG_SIZE-1:0];
                    w_sh_c = w_wide[REG_SIZE];
                end
                2'd1: begin
                    w_wide = {bus.d1, 1'b0} >> w_amt;
                    w_op2  = w_wide[REG_SIZE:1];
                    w_sh_c = w_wide[0];
                end
                2'd2: begin
                    if (int'(w_amt) >= REG_SIZE) begin
                        w_op2  = {REG_SIZE{bus.d1[REG_SIZE-1]}};
                        w_sh_c = bus.d1[REG_SIZE-1];
                    end else begin
                        w_wide_a = $signed({bus.d1, 1'b0}) >>> w_amt;
                        w_op2    = w_wide_a[REG_SIZE:1];
                        w_sh_c   = w_wide_a[0];
                    end
                end
                default: begin
                    w_rot_n = int'(w_amt) % REG_SIZE;
                    w_op2   = rotr(bus.d1, w_rot_n);
                    w_sh_c  = w_op2[REG_SIZE-1];
                end
            endcase
        end
    end

    // ---------------- ALU ----------------
    logic [REG_SIZE-1:0] w_x, w_y, w_logic, w_res;
    logic                w_cin, w_arith, w_ovf, w_test;
    logic [REG_SIZE:0]   w_sum;
    logic [3:0]          w_flags_new;

    always_comb begin
        w_x     = bus.d0;
        w_y     = w_op2;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        w_logic = '0;
        unique case (bus.opcode)
            C_OP_SUB, C_OP_CMP: begin w_y = ~w_op2; w_cin = 1'b1; end
            C_OP_RSB:           begin w_x = w_op2; w_y = ~bus.d0; w_cin = 1'b1; end
            C_OP_ADD, C_OP_CMN: begin w_cin = 1'b0; end
            C_OP_ADC:           begin w_cin = w_c_in; end
            C_OP_SBC:           begin w_y = ~w_op2; w_cin = w_c_in; end
            C_OP_RSC:           begin w_x = w_op2; w_y = ~bus.d0; w_cin = w_c_in; end
            C_OP_AND, C_OP_TST: begin w_arith = 1'b0; w_logic = bus.d0 & w_op2; end
            C_OP_EOR, C_OP_TEQ: begin w_arith = 1'b0; w_logic = bus.d0 ^ w_op2; end
            C_OP_ORR:           begin w_arith = 1'b0; w_logic = bus.d0 | w_op2; end
            C_OP_MOV:           begin w_arith = 1'b0; w_logic = w_op2; end
            C_OP_BIC:           begin w_arith = 1'b0; w_logic = bus.d0 & ~w_op2; end
            default:            begin w_arith = 1'b0; w_logic = ~w_op2; end
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + (REG_SIZE+1)'(w_cin);
        // Subtracts add the inverted operand, so one overflow rule covers both.
        w_ovf = (w_x[REG_SIZE-1] == w_y[REG_SIZE-1]) && (w_sum[REG_SIZE-1] != w_x[REG_SIZE-1]);
        w_res = w_arith ? w_sum[REG_SIZE-1:0] : w_logic;
        w_test = (bus.opcode[3:2] == 2'b10);
        w_flags_new = {w_res[REG_SIZE-1], ~|w_res,
                       w_arith ? w_sum[REG_SIZE] : w_sh_c,
                       w_arith ? w_ovf : flags_q[0]};
    end

    // ---------------- handshake / pipeline ----------------
    logic w_accept, w_mul_req;

`ifdef ALU_MUL_EN
    assign w_mul_req = bus.mul;
    logic [REG_SIZE-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, w_acc_next;
    logic [C_LW-1:0]     cnt_q, cnt_d;
    logic                mul_s_q, mul_s_d;
`else
    logic unused_mul;
    assign unused_mul = bus.mul;
    assign w_mul_req  = 1'b0;
`endif

    assign bus.in_ready  = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.we        = we_q;
    assign bus.flags     = flags_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        data_out_d  = data_out_q;
        we_d        = we_q;
        flags_d     = flags_q;
`ifdef ALU_MUL_EN
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        mul_s_d    = mul_s_q;
        w_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
        if (w_accept && !w_mul_req) begin
            out_valid_d = 1'b1;
            data_out_d  = w_res;
            we_d        = !w_test;
            if (bus.s_bit || w_test) flags_d = w_flags_new;
        end
`ifdef ALU_MUL_EN
        if (w_accept && w_mul_req) begin
            state_d  = S_MUL;
            acc_d    = '0;
            mcand_d  = bus.d0;
            mplier_d = bus.d1;
            cnt_d    = '0;
            mul_s_d  = bus.s_bit;
        end
        if (state_q == S_MUL) begin
            acc_d    = w_acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + C_LW'(1);
            if (cnt_q == C_LW'(REG_SIZE-1)) begin
                state_d     = S_IDLE;
                out_valid_d = 1'b1;
                data_out_d  = w_acc_next;
                we_d        = 1'b1;
                if (mul_s_q) flags_d[3:2] = {w_acc_next[REG_SIZE-1], ~|w_acc_next};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            we_q        <= 1'b0;
            flags_q     <= 4'b0000;
`ifdef ALU_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            mul_s_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            we_q        <= we_d;
            flags_q     <= flags_d;
`ifdef ALU_MUL_EN
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            mul_s_q     <= mul_s_d;
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_unit.sv
`default_nettype none
// =============================================================================
// tb_alu_pipe_unit : scoreboard bench for alu_pipe_unit (32-bit datapath)
// Rev 1.0
// =============================================================================
module tb_alu_pipe_unit;
    localparam int REG_SIZE = 32;
    localparam int SHAMT_W  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_pipe_if #(.REG_SIZE(REG_SIZE), .SHAMT_W(SHAMT_W)) bus ();
    alu_pipe_unit #(.REG_SIZE(REG_SIZE), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        we;
        logic [3:0]  flags;
    } exp_t;

    exp_t       sb_q[$];
    int         pop_cyc[$];
    logic [3:0] model_flags = 4'b0000;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    bit         rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: straight-from-the-architecture model using wide signed/unsigned integers.
    function automatic exp_t model(input logic [3:0] opc, input logic s, input logic bi,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [7:0] im, input logic [3:0] rt,
                                   input logic [7:0] sh, input logic [7:0] sa,
                                   input logic m, input logic [3:0] fl);
        logic [31:0] op2, res, v;
        logic        c, cf, carry, ovf, arith, is_sub, k;
        logic [31:0] p, q;
        int          amt, r;
        longint      u, sv;
        exp_t        e;
        cf = fl[1];
        if (bi) begin
            r   = 2 * int'(rt);
            v   = {24'd0, im};
            op2 = (r == 0) ? v : ((v >> r) | (v << (32 - r)));
            c   = (r != 0) ? op2[31] : cf;
        end else begin
            amt = sh[0] ? int'(sa) : int'(sh[7:3]);
            op2 = b; c = cf;
            if (amt != 0) begin
                case (sh[2:1])
                    2'd0: if (amt < 32) begin op2 = b << amt; c = b[32-amt]; end
                          else if (amt == 32) begin op2 = 0; c = b[0]; end
                          else begin op2 = 0; c = 1'b0; end
                    2'd1: if (amt < 32) begin op2 = b >> amt; c = b[amt-1]; end
                          else if (amt == 32) begin op2 = 0; c = b[31]; end
                          else begin op2 = 0; c = 1'b0; end
                    2'd2: if (amt < 32) begin op2 = 32'($signed(b) >>> amt); c = b[amt-1]; end
                          else begin op2 = {32{b[31]}}; c = b[31]; end
                    default: begin
                        r   = amt % 32;
                        op2 = (r == 0) ? b : ((b >> r) | (b << (32 - r)));
                        c   = op2[31];
                    end
                endcase
            end
        end
        arith = 1'b1; is_sub = 1'b0; p = a; q = op2; k = 1'b0;
        case (opc)
            4'h2, 4'hA: begin is_sub = 1; k = 1; end
            4'h3:       begin is_sub = 1; k = 1; p = op2; q = a; end
            4'h4, 4'hB: k = 0;
            4'h5:       k = cf;
            4'h6:       begin is_sub = 1; k = cf; end
            4'h7:       begin is_sub = 1; k = cf; p = op2; q = a; end
            default:    arith = 1'b0;
        endcase
        if (is_sub) begin
            u  = longint'(p) - longint'(q) - longint'(!k);
            sv = longint'($signed(p)) - longint'($signed(q)) - longint'(!k);
            carry = (u >= 0);
        end else begin
            u  = longint'(p) + longint'(q) + longint'(k);
            sv = longint'($signed(p)) + longint'($signed(q)) + longint'(k);
            carry = u[32];
        end
        ovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        case (opc)
            4'h0, 4'h8: res = a & op2;
            4'h1, 4'h9: res = a ^ op2;
            4'hC:       res = a | op2;
            4'hD:       res = op2;
            4'hE:       res = a & ~op2;
            4'hF:       res = ~op2;
            default:    res = u[31:0];
        endcase
        e.data  = res;
        e.we    = (opc[3:2] != 2'b10);
        e.flags = fl;
        if (s || opc[3:2] == 2'b10)
            e.flags = {res[31], res == 32'd0, arith ? carry : c, arith ? ovf : fl[0]};
`ifdef ALU_MUL_EN
        if (m) begin
            e.data  = 32'(longint'(a) * longint'(b));
            e.we    = 1'b1;
            e.flags = s ? {e.data[31], e.data == 32'd0, fl[1:0]} : fl;
        end
`else
        if (m) e.data = res;
`endif
        return e;
    endfunction

    task automatic issue(input logic [3:0] opc, input logic s, input logic bi,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] im, input logic [3:0] rt,
                         input logic [7:0] sh, input logic [7:0] sa, input logic m);
        bit   acc = 1'b0;
        int   n = 0;
        exp_t e;
        bus.in_valid = 1'b1; bus.opcode = opc; bus.s_bit = s; bus.b_imm = bi;
        bus.d0 = a; bus.d1 = b; bus.imm = im; bus.rot = rt; bus.shift = sh;
        bus.shift_amt = sa; bus.mul = m;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) begin
                e = model(opc, s, bi, a, b, im, rt, sh, sa, m, model_flags);
                model_flags = e.flags;
                sb_q.push_back(e);
            end
            @(posedge clk); #1;
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.mul = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) check("unexpected_out", 1, 0);
            else begin
                e = sb_q.pop_front();
                check("data", bus.data_out, e.data);
                check("we", bus.we, e.we);
                check("flags", bus.flags, e.flags);
                pop_cyc.push_back(cyc);
            end
        end
    end

    always @(posedge clk) if (rand_ready) #1 bus.out_ready = ($urandom_range(0, 3) != 0);

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] sa;
        reset = 1'b1;
        bus.in_valid = 0; bus.opcode = 0; bus.s_bit = 0; bus.b_imm = 0; bus.d0 = 0; bus.d1 = 0;
        bus.imm = 0; bus.rot = 0; bus.shift = 0; bus.shift_amt = 0; bus.mul = 0; bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_we", bus.we, 0);
        check("rst_flags", bus.flags, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // ADD overflow, CMP equal then ADC using the fresh carry
        issue(4'h4, 1, 1, 32'h7FFFFFFF, 0, 8'd1, 4'd0, 8'h00, 8'd0, 0);
        issue(4'hA, 0, 1, 32'd5, 0, 8'd5, 4'd0, 8'h00, 8'd0, 0);
        issue(4'h5, 0, 1, 32'd1, 0, 8'd1, 4'd0, 8'h00, 8'd0, 0);
        // MOV LSR by register amount 32 and 40
        issue(4'hD, 1, 0, 0, 32'h80000001, 0, 0, 8'b0000_0011, 8'd32, 0);
        issue(4'hD, 1, 0, 0, 32'h80000001, 0, 0, 8'b0000_0011, 8'd40, 0);
        // LSL 32, ASR 40, ROR 36 boundary cases
        issue(4'hD, 1, 0, 0, 32'h80000001, 0, 0, 8'b0000_0001, 8'd32, 0);
        issue(4'hD, 1, 0, 0, 32'h80000001, 0, 0, 8'b0000_0101, 8'd40, 0);
        issue(4'hD, 1, 0, 0, 32'h12345678, 0, 0, 8'b0000_0111, 8'd36, 0);
        drain();

        // Stall: result must hold while out_ready is low
        bus.out_ready = 1'b0;
        issue(4'hD, 0, 1, 0, 0, 8'hFF, 4'd4, 8'h00, 8'd0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.data_out, 32'hFF000000);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain();

        // Back-to-back stream
        pop_cyc.delete();
        for (int i = 0; i < 8; i++)
            issue(4'h4, 1'($urandom_range(0, 1)), 0, $urandom, $urandom, 0, 0, 8'h00, 8'd0, 0);
        drain();
        check("stream_count", pop_cyc.size(), 8);
        for (int i = 1; i < pop_cyc.size(); i++)
            check("stream_gap", pop_cyc[i] - pop_cyc[i-1], 1);

        // Random mix with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            sa = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
            issue(4'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                  8'($urandom), 4'($urandom), 8'($urandom), sa, 0);
        end
        rand_ready = 1'b0;
        #1 bus.out_ready = 1'b1;
        drain();

`ifdef ALU_MUL_EN
        pop_cyc.delete();
        issue(4'h4, 1, 0, 32'd12345, 32'd678, 0, 0, 8'h00, 8'd0, 1);
        @(negedge clk);
        check("mul_in_ready", bus.in_ready, 0);
        drain();
        check("mul_count", pop_cyc.size(), 1);
        if (pop_cyc.size() == 1) check("mul_latency", pop_cyc[0] - acc_cyc, REG_SIZE);
        // Reset in the middle of a multiply
        issue(4'h4, 1, 1, 32'h7FFFFFFF, 0, 8'd1, 4'd0, 8'h00, 8'd0, 0);
        drain();
        issue(4'h4, 1, 0, 32'd12345, 32'd678, 0, 0, 8'h00, 8'd0, 1);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb_q.delete();
        model_flags = 4'b0000;
        @(negedge clk);
        check("mulrst_valid", bus.out_valid, 0);
        check("mulrst_flags", bus.flags, 0);
        check("mulrst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        issue(4'h4, 1, 0, 32'd3, 32'd4, 0, 0, 8'h00, 8'd0, 1);
        drain();
`else
        // Without the multiplier the mul request is ignored
        issue(4'h4, 1, 0, 32'd12345, 32'd678, 0, 0, 8'h00, 8'd0, 1);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
